// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: clocked sequencer that sweeps every input vector of a
// combinational function-under-test in ascending order, records the SoP (s1)
// and PoS (s2) outputs as two truth tables, counts vectors where they disagree
// and remembers the lowest disagreeing vector.
// Optional build macro: TTS_STOP_ON_MISMATCH_EN -- when defined, the sweep ends
// on the first vector where s1 != s2.
module truth_table_sweeper #(
    parameter int N_VARS        = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     s1,
    input  logic                     s2,
    output logic [N_VARS-1:0]        vec,
    output logic                     busy,
    output logic                     done,
    output logic [(1<<N_VARS)-1:0]   table_sop,
    output logic [(1<<N_VARS)-1:0]   table_pos,
    output logic [N_VARS:0]          mismatch_cnt,
    output logic [N_VARS-1:0]        first_bad,
    output logic                     first_bad_valid
);

    localparam int TW = 1 << N_VARS;
    localparam int CW = N_VARS + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_APPLY  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]        state_reg, state_next;
    logic [3:0]        settle_cnt_reg;
    logic [N_VARS-1:0] vec_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [TW-1:0]     table_sop_reg, table_pos_reg;
    logic [CW-1:0]     mismatch_cnt_reg;
    logic [N_VARS-1:0] first_bad_reg;
    logic              first_bad_valid_reg;

    logic accept;
    logic sampling;
    logic differ;
    logic last_vec;
    logic stop_now;

    assign accept   = (state_reg == ST_IDLE) && start;
    assign sampling = (state_reg == ST_SAMPLE);
    assign differ   = s1 ^ s2;
    assign last_vec = &vec_reg;

`ifdef TTS_STOP_ON_MISMATCH_EN
    assign stop_now = differ;
`else
    assign stop_now = 1'b0;
`endif

    // Next-state decode for the sweep FSM.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_APPLY;
            ST_APPLY:  state_next = ST_SETTLE;
            ST_SETTLE: if (settle_cnt_reg == 4'd1) state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = (last_vec || stop_now) ? ST_DONE : ST_APPLY;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State, vector, settle counter, status and mismatch bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg           <= ST_IDLE;
            settle_cnt_reg      <= 4'd0;
            vec_reg             <= '0;
            busy_reg            <= 1'b0;
            done_reg            <= 1'b0;
            mismatch_cnt_reg    <= '0;
            first_bad_reg       <= '0;
            first_bad_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            // done is high exactly while the FSM sits in DONE
            done_reg  <= sampling && (state_next == ST_DONE);

            if (state_reg == ST_APPLY)
                settle_cnt_reg <= 4'(SETTLE_CYCLES);
            else if (state_reg == ST_SETTLE)
                settle_cnt_reg <= settle_cnt_reg - 4'd1;

            if (accept)
                busy_reg <= 1'b1;
            else if (state_reg == ST_DONE)
                busy_reg <= 1'b0;

            if (accept) begin
                vec_reg             <= '0;
                mismatch_cnt_reg    <= '0;
                first_bad_reg       <= '0;
                first_bad_valid_reg <= 1'b0;
            end else if (sampling) begin
                // vec stays on the final/failing index after the sweep ends
                if (!last_vec && !stop_now)
                    vec_reg <= vec_reg + N_VARS'(1);
                if (differ) begin
                    mismatch_cnt_reg <= mismatch_cnt_reg + CW'(1);
                    if (!first_bad_valid_reg) begin
                        first_bad_reg       <= vec_reg;
                        first_bad_valid_reg <= 1'b1;
                    end
                end
            end
        end
    end

    // One flop pair per truth-table row, written when its vector is sampled.
    generate
        for (genvar gi = 0; gi < TW; gi++) begin : g_row
            localparam logic [N_VARS-1:0] ROW = gi;
            always_ff @(posedge clk) begin
                if (reset || accept) begin
                    table_sop_reg[gi] <= 1'b0;
                    table_pos_reg[gi] <= 1'b0;
                end else if (sampling && (vec_reg == ROW)) begin
                    table_sop_reg[gi] <= s1;
                    table_pos_reg[gi] <= s2;
                end
            end
        end
    endgenerate

    assign vec             = vec_reg;
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign table_sop       = table_sop_reg;
    assign table_pos       = table_pos_reg;
    assign mismatch_cnt    = mismatch_cnt_reg;
    assign first_bad       = first_bad_reg;
    assign first_bad_valid = first_bad_valid_reg;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper. The function-under-test is modelled
// as a 16-bit constant (minterms 0,3,5,6,8,10,12,14,15 -> 16'hD569); s2 is the
// same function, its inverse, or the function with one corrupted row.
// Cycle numbering: the start edge moves the FSM into APPLY, which is cycle 1.
module tb_truth_table_sweeper;

    localparam logic [15:0] FUNC = 16'hD569;

    logic        clk = 1'b0;
    logic        reset, start;
    logic        s1, s2;
    logic [3:0]  vec;
    logic        busy, done;
    logic [15:0] table_sop, table_pos;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_bad;
    logic        first_bad_valid;

    // second instance with a longer settle window
    logic        start3;
    logic        s1b, s2b;
    logic [3:0]  vec3;
    logic        busy3, done3;
    logic [15:0] table_sop3, table_pos3;
    logic [4:0]  mismatch_cnt3;
    logic [3:0]  first_bad3;
    logic        first_bad_valid3;

    int tests = 0;
    int fails = 0;
    int mode  = 0;   // 0: s2=s1, 1: s2=~s1, 2: s2 corrupted at vec 4'hA

    always #5 clk = ~clk;

    always_comb begin
        logic [15:0] f;
        f  = FUNC;
        s1 = f[vec];
        s2 = s1;
        if (mode == 1) s2 = ~s1;
        if (mode == 2 && vec == 4'hA) s2 = ~s1;
    end

    always_comb begin
        logic [15:0] f;
        f   = FUNC;
        s1b = f[vec3];
        s2b = s1b;
    end

    truth_table_sweeper #(.N_VARS(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .start(start), .s1(s1), .s2(s2),
        .vec(vec), .busy(busy), .done(done),
        .table_sop(table_sop), .table_pos(table_pos),
        .mismatch_cnt(mismatch_cnt), .first_bad(first_bad),
        .first_bad_valid(first_bad_valid)
    );

    truth_table_sweeper #(.N_VARS(4), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .s1(s1b), .s2(s2b),
        .vec(vec3), .busy(busy3), .done(done3),
        .table_sop(table_sop3), .table_pos(table_pos3),
        .mismatch_cnt(mismatch_cnt3), .first_bad(first_bad3),
        .first_bad_valid(first_bad_valid3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Pulse start on the main instance, then watch up to 'budget' cycles.
    // Returns the cycle of the first done pulse (0 if none), the number of
    // done pulses, and whether busy ever dropped before done.
    task automatic sweep(input int start_at, input int budget,
                         output int done_at, output int done_cnt, output int busy_gap);
        done_at  = 0;
        done_cnt = 0;
        busy_gap = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            if (!busy && done_at == 0) busy_gap = 1;
            start = (n == start_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        int d_at, d_cnt, gap;
        reset  = 1'b1;
        start  = 1'b1;   // start together with reset must be ignored
        start3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        chk("reset_vec", 32'(vec), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_tables", {table_sop, table_pos}, 32'h0);
        chk("reset_cnt", 32'(mismatch_cnt), 32'h0);
        chk("reset_fbv", 32'({first_bad, first_bad_valid}), 32'h0);

        // correct SoP/PoS pair
        mode = 0;
        sweep(0, 60, d_at, d_cnt, gap);
        chk("ok_done_cycle", 32'(d_at), 32'd49);
        chk("ok_done_count", 32'(d_cnt), 32'd1);
        chk("ok_busy_held", 32'(gap), 32'd0);
        chk("ok_busy_after", 32'(busy), 32'h0);
        chk("ok_table_sop", 32'(table_sop), 32'hD569);
        chk("ok_table_pos", 32'(table_pos), 32'hD569);
        chk("ok_cnt", 32'(mismatch_cnt), 32'd0);
        chk("ok_fbv", 32'(first_bad_valid), 32'h0);
        chk("ok_vec_hold", 32'(vec), 32'hF);

        // PoS inverted everywhere
        mode = 1;
        sweep(0, 60, d_at, d_cnt, gap);
`ifdef TTS_STOP_ON_MISMATCH_EN
        chk("inv_done_cycle", 32'(d_at), 32'd4);
        chk("inv_table_sop", 32'(table_sop), 32'h0001);
        chk("inv_table_pos", 32'(table_pos), 32'h0000);
        chk("inv_cnt", 32'(mismatch_cnt), 32'd1);
`else
        chk("inv_done_cycle", 32'(d_at), 32'd49);
        chk("inv_table_sop", 32'(table_sop), 32'hD569);
        chk("inv_table_pos", 32'(table_pos), 32'h2A96);
        chk("inv_cnt", 32'(mismatch_cnt), 32'd16);
`endif
        chk("inv_first_bad", 32'(first_bad), 32'h0);
        chk("inv_fbv", 32'(first_bad_valid), 32'h1);

        // single corrupted row at vec=4'hA
        mode = 2;
        sweep(0, 60, d_at, d_cnt, gap);
`ifdef TTS_STOP_ON_MISMATCH_EN
        chk("one_done_cycle", 32'(d_at), 32'd34);
        chk("one_vec", 32'(vec), 32'hA);
        chk("one_table_sop", 32'(table_sop), 32'h0569);
        chk("one_table_pos", 32'(table_pos), 32'h0169);
`else
        chk("one_done_cycle", 32'(d_at), 32'd49);
        chk("one_vec", 32'(vec), 32'hF);
        chk("one_table_sop", 32'(table_sop), 32'hD569);
        chk("one_table_pos", 32'(table_pos), 32'hD169);
`endif
        chk("one_cnt", 32'(mismatch_cnt), 32'd1);
        chk("one_first_bad", 32'(first_bad), 32'hA);
        chk("one_fbv", 32'(first_bad_valid), 32'h1);

        // start re-pulsed mid-sweep is ignored
        mode = 0;
        sweep(20, 60, d_at, d_cnt, gap);
        chk("restart_done_cycle", 32'(d_at), 32'd49);
        chk("restart_done_count", 32'(d_cnt), 32'd1);
        chk("restart_table", 32'(table_pos), 32'hD569);
        chk("restart_cnt", 32'(mismatch_cnt), 32'd0);

        // reset mid-sweep aborts everything (inverted pair so state is dirty)
        mode = 1;
        sweep(0, 24, d_at, d_cnt, gap);
        chk("abort_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_vec", 32'(vec), 32'h0);
        chk("abort_tables", {table_sop, table_pos}, 32'h0);
        chk("abort_cnt", 32'(mismatch_cnt), 32'd0);
        chk("abort_fbv", 32'(first_bad_valid), 32'h0);
        mode = 0;
        sweep(0, 60, d_at, d_cnt, gap);
        chk("abort_rerun_cycle", 32'(d_at), 32'd49);
        chk("abort_rerun_table", 32'(table_sop), 32'hD569);

        // SETTLE_CYCLES=3 instance: 16*5+1 cycles
        begin
            int n3;
            n3 = 0;
            start3 = 1'b1;
            @(posedge clk); #1;
            start3 = 1'b0;
            for (int n = 1; n <= 100; n++) begin
                if (done3 && n3 == 0) n3 = n;
                @(posedge clk); #1;
            end
            chk("s3_done_cycle", 32'(n3), 32'd81);
            chk("s3_table_sop", 32'(table_sop3), 32'hD569);
            chk("s3_cnt", 32'(mismatch_cnt3), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that drives the 4-input boolean datapath (SoP and PoS implementations of the same function) through all 2^N_VARS input vectors in ascending order.
- Samples both implementation outputs for each vector and records a truth table per implementation.
- Counts SoP/PoS disagreements and flags the first failing vector.
- Sits between a start/status interface and the combinational function-under-test; replaces hand-written stimulus sequences with a clocked, self-checking sweep.

Parameters:
- N_VARS, 4, number of function inputs; vector width. Table width is 2^N_VARS.
- SETTLE_CYCLES, 1, cycles waited after applying a vector before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; sampled only in IDLE.
- s1  input  1  SoP output of the function-under-test for the current vec.
- s2  input  1  PoS output of the function-under-test for the current vec.
- vec  output  N_VARS  applied input vector; vec[3]=x, vec[2]=y, vec[1]=w, vec[0]=z for N_VARS=4.
- busy  output  1  high from the cycle after start is accepted until the DONE state is left.
- done  output  1  one-cycle pulse when a sweep completes.
- table_sop  output  2^N_VARS  bit i = s1 sampled with vec=i.
- table_pos  output  2^N_VARS  bit i = s2 sampled with vec=i.
- mismatch_cnt  output  N_VARS+1  number of vectors where s1 != s2.
- first_bad  output  N_VARS  lowest vector index with s1 != s2.
- first_bad_valid  output  1  high once first_bad holds a valid index.

Behaviour:
- One clock domain; all state updates on the rising edge of clk. reset is synchronous, active-high, and has priority over all other inputs.
- Reset values: vec=0, busy=0, done=0, table_sop=0, table_pos=0, mismatch_cnt=0, first_bad=0, first_bad_valid=0; FSM goes to IDLE.
- FSM states: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE:
  - If start=1, clear vec, both tables, mismatch_cnt, first_bad and first_bad_valid, then go to APPLY.
  - Otherwise stay in IDLE; previous results are held.
- APPLY: vec holds the current index; load the settle counter with SETTLE_CYCLES; go to SETTLE.
- SETTLE: decrement the counter; go to SAMPLE when the count reaches 0. Stay exactly SETTLE_CYCLES cycles.
- SAMPLE:
  - Write table_sop[vec]=s1 and table_pos[vec]=s2.
  - If s1!=s2, increment mismatch_cnt.
  - If s1!=s2 and first_bad_valid=0, set first_bad=vec and first_bad_valid=1.
  - If vec is all ones, go to DONE. Otherwise increment vec and go to APPLY.
- DONE: done=1 for this single cycle; go to IDLE. busy drops in the IDLE cycle that follows.
- Timing: each vector takes SETTLE_CYCLES+2 cycles. A full sweep takes 2^N_VARS*(SETTLE_CYCLES+2) cycles, followed by 1 DONE cycle. With defaults this is 48 cycles, and done is asserted 49 cycles after the start edge.
- Wrap-around: vec never wraps during a sweep. After DONE it holds the last index (all ones) until the next start.
- start while busy is ignored; no queuing.
- start asserted in the same cycle as reset: reset wins.
- Reset mid-sweep aborts the sweep; all outputs return to their reset values.
- mismatch_cnt reaches at most 2^N_VARS; its width is sufficient, so no saturation is needed.
- Results (tables, counts, first_bad) are stable from the done cycle until the next accepted start.

Optional Feature:
- Macro: TTS_STOP_ON_MISMATCH_EN.
- Defined: SAMPLE goes to DONE on the first vector where s1!=s2.
  - vec holds the failing index, mismatch_cnt=1, first_bad_valid=1.
  - Table bits above the failing index remain 0.
- Undefined: the full sweep always completes regardless of mismatches.

Test Plan:
- Reset, then start with the correct SoP/PoS pair connected (minterms 0,3,5,6,8,10,12,14,15) -> done 49 cycles after the start edge; table_sop=table_pos=16'hD569; mismatch_cnt=0; first_bad_valid=0.
- PoS input forced to ~s1 -> table_pos=16'h2A96, mismatch_cnt=16, first_bad=0, first_bad_valid=1.
- s2 corrupted only at vec=4'b1010 -> mismatch_cnt=1, first_bad=4'hA. With TTS_STOP_ON_MISMATCH_EN defined: done after 11*3+1=34 cycles, vec=4'hA.
- start pulsed again at cycle 20 of a sweep -> ignored; single done at cycle 49; results unchanged.
- reset asserted at cycle 25 of a sweep -> next cycle: busy=0, vec=0, tables=0, mismatch_cnt=0; a new start completes normally.
- SETTLE_CYCLES=3 -> done at 16*5+1=81 cycles; s1/s2 sampled exactly 4 cycles after each vec change.
